// File: rtl/ode_pkg.sv
// Shared constants and FSM encoding for the ODE term accumulator.
// Saturation is enabled in the datapath by defining ODE_ACC_SAT_EN.
package ode_pkg;

  localparam int unsigned WIDTH = 20;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_addsub_sat.sv
// Combinational add/subtract with two's-complement overflow detection.
// Define ODE_ACC_SAT_EN to clamp overflowed results instead of wrapping.
module acc_addsub_sat #(
  parameter int unsigned WIDTH = ode_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ovf
);

`ifdef ODE_ACC_SAT_EN
  localparam logic [WIDTH-1:0] L_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] L_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;

  always_comb begin
    w_b   = i_sub ? ~i_b : i_b;
    w_sum = i_a + w_b + {{(WIDTH-1){1'b0}}, i_sub};
    // Overflow: both operands share a sign that the sum does not.
    o_ovf = (i_a[WIDTH-1] & w_b[WIDTH-1] & ~w_sum[WIDTH-1]) |
            (~i_a[WIDTH-1] & ~w_b[WIDTH-1] & w_sum[WIDTH-1]);
`ifdef ODE_ACC_SAT_EN
    o_result = o_ovf ? (i_a[WIDTH-1] ? L_MIN : L_MAX) : w_sum;
`else
    o_result = w_sum;
`endif
  end

endmodule

// File: rtl/ode_term_accumulator.sv
// Signed term accumulator with valid/ready in/out handshakes and sticky overflow.
// Build option ODE_ACC_SAT_EN selects saturating instead of wrapping arithmetic.
module ode_term_accumulator
  import ode_pkg::*;
#(
  parameter int unsigned WIDTH     = ode_pkg::WIDTH,
  parameter int unsigned MAX_TERMS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_sub,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_ovf,
  output logic [$clog2(MAX_TERMS+1)-1:0] out_count
);

  localparam int unsigned CW = $clog2(MAX_TERMS + 1);
  localparam logic [CW-1:0] L_MAX_T = CW'(MAX_TERMS);
  localparam logic [CW-1:0] L_ONE   = CW'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_result;
  logic             w_v;
  logic             w_accept;
  logic [CW-1:0]    w_cnt_nx;
  logic             w_ovf_nx;
  logic             w_close;

  acc_addsub_sat #(.WIDTH(WIDTH)) u_addsub (
    .i_a      (w_a),
    .i_b      (in_data),
    .i_sub    (in_sub),
    .o_result (w_result),
    .o_ovf    (w_v)
  );

  always_comb begin
    in_ready = ~rst & (r_state != ST_DONE);
    w_accept = in_valid & in_ready;
    w_a      = (r_state == ST_IDLE) ? '0 : r_acc;
    w_cnt_nx = (r_state == ST_IDLE) ? L_ONE : r_cnt + L_ONE;
    w_ovf_nx = (r_state == ST_IDLE) ? w_v : (r_ovf | w_v);
    // Count limit and in_last may coincide; either one closes exactly once.
    w_close  = in_last | (w_cnt_nx == L_MAX_T);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_result;
            r_cnt <= w_cnt_nx;
            r_ovf <= w_ovf_nx;
            if (w_close) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_acc;
  assign out_ovf   = r_ovf;
  assign out_count = r_cnt;

endmodule

// File: tb/tb_ode_term_accumulator.sv
// Directed self-checking bench for ode_term_accumulator (20-bit, 16 terms).
module tb_ode_term_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic        in_sub;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic        out_ovf;
  logic [4:0]  out_count;

  int checks = 0;
  int errors = 0;

`ifdef ODE_ACC_SAT_EN
  localparam logic [19:0] E_POS_OVF = 20'h7FFFF;
  localparam logic [19:0] E_NEG_MIN = 20'h7FFFF;
  localparam logic [19:0] E_STICKY  = 20'h7FFFE;
`else
  localparam logic [19:0] E_POS_OVF = 20'h80010;
  localparam logic [19:0] E_NEG_MIN = 20'h80000;
  localparam logic [19:0] E_STICKY  = 20'h8000F;
`endif

  always #5 clk = ~clk;

  ode_term_accumulator #(.WIDTH(20), .MAX_TERMS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] d, input logic sub, input logic last);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = sub;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_sub   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [19:0] d,
                               input logic [4:0] c, input logic o);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"},  {12'd0, out_data},  {12'd0, d});
    check({tag, "_count"}, {27'd0, out_count}, {27'd0, c});
    check({tag, "_ovf"},   {31'd0, out_ovf},   {31'd0, o});
    check({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_cleared"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_again"},   {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset held 3 cycles
    repeat (3) tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {12'd0, out_data},  32'd0);
    check("rst_out_count", {27'd0, out_count}, 32'd0);
    check("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 5 - 3 + 10 = 12
    send(20'd5, 1'b0, 1'b0);
    send(20'd3, 1'b1, 1'b0);
    check("basic_no_early_valid", {31'd0, out_valid}, 32'd0);
    send(20'd10, 1'b0, 1'b1);
    check("basic_valid_next_cycle", {31'd0, out_valid}, 32'd1);
    expect_result("basic", 20'd12, 5'd3, 1'b0);
    take_result("basic");

    // Negative result: -4 - 6 = -10
    send(20'hFFFFC, 1'b0, 1'b0);
    send(20'd6, 1'b1, 1'b1);
    expect_result("neg", 20'hFFFF6, 5'd2, 1'b0);
    take_result("neg");

    // Positive overflow on the closing term
    send(20'h7FFF0, 1'b0, 1'b0);
    send(20'h00020, 1'b0, 1'b1);
    expect_result("pos_ovf", E_POS_OVF, 5'd2, 1'b1);
    take_result("pos_ovf");

    // 0 - 0x80000 as a single term
    send(20'h80000, 1'b1, 1'b1);
    expect_result("sub_min", E_NEG_MIN, 5'd1, 1'b1);
    take_result("sub_min");

    // Overflow mid-sequence stays sticky after a clean term
    send(20'h7FFF0, 1'b0, 1'b0);
    send(20'h00020, 1'b0, 1'b0);
    send(20'h00001, 1'b1, 1'b1);
    expect_result("sticky", E_STICKY, 5'd3, 1'b1);
    take_result("sticky");

    // Idle gap inside a sequence holds state
    send(20'd4, 1'b0, 1'b0);
    repeat (3) tick();
    check("gap_no_valid", {31'd0, out_valid}, 32'd0);
    send(20'd9, 1'b0, 1'b1);
    expect_result("gap", 20'd13, 5'd2, 1'b0);
    take_result("gap");

    // Auto-close at 16 terms
    for (int i = 0; i < 16; i++) send(20'd1, 1'b0, 1'b0);
    expect_result("max16", 20'd16, 5'd16, 1'b0);
    in_valid = 1'b1;
    in_data  = 20'd99;
    #1;
    check("max16_17th_stalls", {31'd0, in_ready}, 32'd0);

    // Backpressure: 5 cycles with out_ready low and a term offered
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data",  {12'd0, out_data},  32'd16);
      check("bp_count", {27'd0, out_count}, 32'd16);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    take_result("max16");

    // Last flag coinciding with the 16th term closes once
    for (int i = 0; i < 15; i++) send(20'd2, 1'b0, 1'b0);
    send(20'd2, 1'b0, 1'b1);
    expect_result("last_at_max", 20'd32, 5'd16, 1'b0);
    take_result("last_at_max");

    // Reset during ACCUM discards the partial sum
    send(20'd1, 1'b0, 1'b0);
    send(20'd2, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_accum_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_accum_valid", {31'd0, out_valid}, 32'd0);
    check("rst_accum_data",  {12'd0, out_data},  32'd0);
    check("rst_accum_count", {27'd0, out_count}, 32'd0);
    send(20'd7, 1'b0, 1'b1);
    expect_result("after_rst", 20'd7, 5'd1, 1'b0);

    // Reset during DONE drops the result without a handshake
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_done_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done_ovf",   {31'd0, out_ovf},   32'd0);
    check("rst_done_ready", {31'd0, in_ready},  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
